risc_toy_fetch_stage: RTL and testbench
=======================================

Name: risc_toy_fetch_stage

Overview:
Instruction-fetch stage of the RISC_TOY 5-stage pipeline. It owns the PC, drives the instruction-memory request (IREQ/IADDR), captures INSTR into the IF/ID pipeline register, and slices the opcode and register-address fields for the decode stage. It accepts stall requests from the hazard unit and redirect requests from the branch/jump resolution in EX.

Parameters:
RESET_PC, 30'h0, word address loaded into the PC at reset.
CNT_W, 32, width of the fetched-instruction performance counter.

Ports:
CLK  input  1  clock, rising-edge.
RSTN  input  1  reset, asynchronous, active-low.
STALL  input  1  hazard unit: hold the PC and IF/ID contents.
REDIRECT  input  1  EX stage: taken branch/jump; load the PC and squash IF/ID.
REDIRECT_ADDR  input  30  word-address target for REDIRECT.
IREQ  output  1  instruction-memory request.
IADDR  output  30  instruction word address (equals the PC).
INSTR  input  32  instruction data; combinational read, valid in the same cycle as IADDR.
FI_VALID  output  1  IF/ID holds a real instruction.
FI_INSTR  output  32  IF/ID instruction.
FI_IADDR  output  30  word address of FI_INSTR.
FI_LINK  output  32  byte link value for BRL/JL: {FI_IADDR+1, 2'b00}.
FI_OP  output  5  FI_INSTR[31:27].
FI_RA  output  5  FI_INSTR[26:22].
FI_RB  output  5  FI_INSTR[21:17].
FI_RC  output  5  FI_INSTR[16:12].
FETCH_CNT  output  CNT_W  count of instructions accepted into IF/ID.

Behaviour:
- Two-state FSM:
  - BOOT is entered on reset. RUN follows unconditionally on the next edge.
  - In BOOT: IREQ=0 and the PC is held.
  - REDIRECT and STALL are ignored in BOOT.
- Reset values (asynchronous):
  - state=BOOT, PC=RESET_PC, FETCH_CNT=0.
  - FI_VALID=0, FI_INSTR=0, FI_IADDR=0.
  - Derived outputs at reset: IREQ=0, FI_LINK=32'h4, FI_OP/FI_RA/FI_RB/FI_RC all 0.
- Combinational outputs:
  - IADDR=PC at all times.
  - IREQ = (state==RUN) & ~STALL & ~REDIRECT.
  - FI_OP, FI_RA, FI_RB, FI_RC and FI_LINK are derived combinationally from the IF/ID registers.
- RUN edge priority (highest first):
  1. REDIRECT:
     - PC <= REDIRECT_ADDR.
     - FI_VALID <= 0 and FI_INSTR <= 0 (bubble). FI_IADDR is held.
     - FETCH_CNT is not incremented.
     - REDIRECT beats STALL when both are asserted; the older instruction in EX wins.
  2. STALL:
     - PC, FI_*, and FETCH_CNT are all held.
     - INSTR is ignored.
  3. Otherwise:
     - FI_INSTR <= INSTR, FI_IADDR <= PC, FI_VALID <= 1.
     - PC <= PC+1.
     - FETCH_CNT <= FETCH_CNT+1.
- Latency: an instruction at address A appears on FI_* exactly one edge after IADDR=A with IREQ=1.
- A redirect costs one bubble: the redirect-target instruction reaches FI_* two edges after the REDIRECT edge.
- Bubbles: opcode 0 is ADDI, so FI_INSTR=0 is NOT a no-op. Downstream stages must qualify every action with FI_VALID.
- Wrap-around:
  - PC+1 wraps from 30'h3FFFFFFF to 0.
  - FI_LINK computes FI_IADDR+1 in 30 bits before the shift, so it wraps to 32'h0.
  - FETCH_CNT wraps modulo 2^CNT_W.
- Reset mid-operation: all state returns to reset values immediately, without waiting for CLK. The next fetch after reset is RESET_PC, via BOOT.
- Back-to-back REDIRECTs: each one reloads the PC. FI_VALID stays 0 until the first cycle without REDIRECT and without STALL.

Decomposition:
- Shared package risc_toy_pkg holds:
  - opcode constants ADDI=0 through STR=22;
  - field bit positions: OP 31:27, RA 26:22, RB 21:17, RC 16:12;
  - FSM state encoding BOOT/RUN.
- No sub-module; the PC, FSM, and IF/ID register all live in one module (about 150 RTL lines).

Test Plan:
- Reset then free-run with INSTR=IADDR-tagged data → cycle 0: IREQ=0, IADDR=0. Next edge: IREQ=1. FI_IADDR sequence 0,1,2,3 with FI_VALID=1. FETCH_CNT=4 after four fetch edges.
- At PC=5, hold STALL for 3 cycles → IADDR stays 5, IREQ=0, FI_* unchanged, FETCH_CNT unchanged. After release, FI_IADDR=5 on the next edge.
- REDIRECT with REDIRECT_ADDR=30'h100 while PC=8 → next edge: PC=30'h100, FI_VALID=0, FI_INSTR=0. Following edge: FI_IADDR=30'h100, FI_VALID=1.
- STALL and REDIRECT (addr 30'h20) asserted together → redirect taken: PC=30'h20, FI_VALID=0. FETCH_CNT unchanged.
- Set RESET_PC=30'h3FFFFFFF → first fetch: FI_IADDR=30'h3FFFFFFF, FI_LINK=32'h0. Next IADDR=0.
- Deassert RSTN asynchronously mid-run at PC=30'h40 → outputs immediately at reset values. After release, one BOOT cycle, then fetch from RESET_PC.

Source files
------------

// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: opcodes, instruction field positions and the
// fetch-stage FSM encoding.
package risc_toy_pkg;

  localparam logic [4:0] ADDI = 5'd0;
  localparam logic [4:0] ANDI = 5'd1;
  localparam logic [4:0] ORI  = 5'd2;
  localparam logic [4:0] MOVI = 5'd3;
  localparam logic [4:0] ADD  = 5'd4;
  localparam logic [4:0] SUB  = 5'd5;
  localparam logic [4:0] NEG  = 5'd6;
  localparam logic [4:0] NOT  = 5'd7;
  localparam logic [4:0] AND  = 5'd8;
  localparam logic [4:0] OR   = 5'd9;
  localparam logic [4:0] XOR  = 5'd10;
  localparam logic [4:0] LSR  = 5'd11;
  localparam logic [4:0] ASR  = 5'd12;
  localparam logic [4:0] SHL  = 5'd13;
  localparam logic [4:0] ROR  = 5'd14;
  localparam logic [4:0] BR   = 5'd15;
  localparam logic [4:0] BRL  = 5'd16;
  localparam logic [4:0] J    = 5'd17;
  localparam logic [4:0] JL   = 5'd18;
  localparam logic [4:0] LD   = 5'd19;
  localparam logic [4:0] LDR  = 5'd20;
  localparam logic [4:0] ST   = 5'd21;
  localparam logic [4:0] STR  = 5'd22;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 22;
  localparam int RB_MSB = 21;
  localparam int RB_LSB = 17;
  localparam int RC_MSB = 16;
  localparam int RC_LSB = 12;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/risc_toy_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// combinational-read instruction memory (slave).
interface risc_toy_fetch_stage_if;

  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;

  modport master (output IREQ, output IADDR, input INSTR);
  modport slave  (input IREQ, input IADDR, output INSTR);

endinterface

// File: rtl/risc_toy_fetch_stage.sv
// RISC_TOY instruction-fetch stage: PC, BOOT/RUN FSM, IF/ID register and
// decode-field slicing.
module risc_toy_fetch_stage
  import risc_toy_pkg::*;
#(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter int          CNT_W    = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  STALL,
  input  logic                  REDIRECT,
  input  logic [29:0]           REDIRECT_ADDR,
  risc_toy_fetch_stage_if.master imem,
  output logic                  FI_VALID,
  output logic [31:0]           FI_INSTR,
  output logic [29:0]           FI_IADDR,
  output logic [31:0]           FI_LINK,
  output logic [4:0]            FI_OP,
  output logic [4:0]            FI_RA,
  output logic [4:0]            FI_RB,
  output logic [4:0]            FI_RC,
  output logic [CNT_W-1:0]      FETCH_CNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     r_state;
  fetch_state_e     w_nextState;
  logic             w_fetch;
  logic             w_redirect;
  logic [29:0]      r_pc;
  logic             r_valid;
  logic [31:0]      r_instr;
  logic [29:0]      r_iaddr;
  logic [CNT_W-1:0] r_fetchCnt;
  logic [29:0]      w_linkWord;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= BOOT;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BOOT:    w_nextState = RUN;
      RUN:     w_nextState = RUN;
      default: w_nextState = BOOT;
    endcase
  end

  // Redirect outranks stall: the branch in EX is older than the hazard.
  always_comb begin
    w_redirect = 1'b0;
    w_fetch    = 1'b0;
    if (r_state == RUN) begin
      w_redirect = REDIRECT;
      w_fetch    = ~STALL & ~REDIRECT;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_iaddr    <= 30'h0;
      r_fetchCnt <= '0;
    end else if (w_redirect) begin
      r_pc    <= REDIRECT_ADDR;
      r_valid <= 1'b0;
      r_instr <= 32'h0;
    end else if (w_fetch) begin
      r_pc       <= r_pc + 30'd1;
      r_valid    <= 1'b1;
      r_instr    <= imem.INSTR;
      r_iaddr    <= r_pc;
      r_fetchCnt <= r_fetchCnt + CNT_ONE;
    end
  end

  // Increment in 30 bits before the shift so the link wraps to zero.
  assign w_linkWord = r_iaddr + 30'd1;

  assign imem.IREQ  = w_fetch;
  assign imem.IADDR = r_pc;
  assign FI_VALID   = r_valid;
  assign FI_INSTR   = r_instr;
  assign FI_IADDR   = r_iaddr;
  assign FI_LINK    = {w_linkWord, 2'b00};
  assign FI_OP      = r_instr[OP_MSB:OP_LSB];
  assign FI_RA      = r_instr[RA_MSB:RA_LSB];
  assign FI_RB      = r_instr[RB_MSB:RB_LSB];
  assign FI_RC      = r_instr[RC_MSB:RC_LSB];
  assign FETCH_CNT  = r_fetchCnt;

endmodule

// File: tb/tb_risc_toy_fetch_stage.sv
// Directed bench for risc_toy_fetch_stage: a RESET_PC=0 instance for the main
// flow and a RESET_PC=30'h3FFFFFFF instance for address wrap-around.
module tb_risc_toy_fetch_stage;

  logic        CLK;
  logic        RSTN;
  logic        STALL;
  logic        REDIRECT;
  logic [29:0] REDIRECT_ADDR;
  logic        rstnB;
  int          nChecks;
  int          nErrors;

  logic        aValid, bValid;
  logic [31:0] aInstr, bInstr, aLink, bLink, aCnt, bCnt;
  logic [29:0] aIaddr, bIaddr;
  logic [4:0]  aOp, aRa, aRb, aRc, bOp, bRa, bRb, bRc;

  risc_toy_fetch_stage_if imemA ();
  risc_toy_fetch_stage_if imemB ();

  // Memory words tagged from the address so every field is predictable.
  function automatic logic [31:0] tag(input logic [29:0] a);
    logic [4:0] b;
    b = a[4:0];
    return {b, b + 5'd1, b + 5'd2, b + 5'd3, a[11:0]};
  endfunction

  assign imemA.INSTR = tag(imemA.IADDR);
  assign imemB.INSTR = tag(imemB.IADDR);

  risc_toy_fetch_stage #(.RESET_PC(30'h0), .CNT_W(32)) dutA (
    .CLK(CLK), .RSTN(RSTN), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_ADDR(REDIRECT_ADDR), .imem(imemA),
    .FI_VALID(aValid), .FI_INSTR(aInstr), .FI_IADDR(aIaddr), .FI_LINK(aLink),
    .FI_OP(aOp), .FI_RA(aRa), .FI_RB(aRb), .FI_RC(aRc), .FETCH_CNT(aCnt)
  );

  risc_toy_fetch_stage #(.RESET_PC(30'h3FFFFFFF), .CNT_W(32)) dutB (
    .CLK(CLK), .RSTN(rstnB), .STALL(1'b0), .REDIRECT(1'b0),
    .REDIRECT_ADDR(30'h0), .imem(imemB),
    .FI_VALID(bValid), .FI_INSTR(bInstr), .FI_IADDR(bIaddr), .FI_LINK(bLink),
    .FI_OP(bOp), .FI_RA(bRa), .FI_RB(bRb), .FI_RC(bRc), .FETCH_CNT(bCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; rstnB = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_ADDR = 30'h0;
    #1;
    nChecks++; if (imemA.IREQ !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_ireq got %b want 0", imemA.IREQ); end
    nChecks++; if (imemA.IADDR !== 30'h0) begin nErrors++; $display("[TB] FAIL reset_iaddr got %h want 0", imemA.IADDR); end
    nChecks++; if (aValid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_valid got %b want 0", aValid); end
    nChecks++; if (aInstr !== 32'h0) begin nErrors++; $display("[TB] FAIL reset_instr got %h want 0", aInstr); end
    nChecks++; if (aIaddr !== 30'h0) begin nErrors++; $display("[TB] FAIL reset_fi_iaddr got %h want 0", aIaddr); end
    nChecks++; if (aLink !== 32'h4) begin nErrors++; $display("[TB] FAIL reset_link got %h want 4", aLink); end
    nChecks++; if ({aOp, aRa, aRb, aRc} !== 20'h0) begin nErrors++; $display("[TB] FAIL reset_fields got %h want 0", {aOp, aRa, aRb, aRc}); end
    nChecks++; if (aCnt !== 32'h0) begin nErrors++; $display("[TB] FAIL reset_cnt got %0d want 0", aCnt); end
    step();
    step();
    RSTN = 1'b1;
    #1;
    nChecks++; if (imemA.IREQ !== 1'b0) begin nErrors++; $display("[TB] FAIL boot_ireq got %b want 0", imemA.IREQ); end
    nChecks++; if (imemA.IADDR !== 30'h0) begin nErrors++; $display("[TB] FAIL boot_iaddr got %h want 0", imemA.IADDR); end
  endtask

  task automatic test_free_run();
    step();
    nChecks++; if (imemA.IREQ !== 1'b1) begin nErrors++; $display("[TB] FAIL run_ireq got %b want 1", imemA.IREQ); end
    nChecks++; if (imemA.IADDR !== 30'h0) begin nErrors++; $display("[TB] FAIL run_iaddr got %h want 0", imemA.IADDR); end
    nChecks++; if (aValid !== 1'b0) begin nErrors++; $display("[TB] FAIL boot_no_fetch got %b want 0", aValid); end
    for (int k = 0; k < 4; k++) begin
      step();
      nChecks++; if (aValid !== 1'b1) begin nErrors++; $display("[TB] FAIL run_valid[%0d] got %b want 1", k, aValid); end
      nChecks++; if (aIaddr !== 30'(k)) begin nErrors++; $display("[TB] FAIL run_fi_iaddr[%0d] got %h want %h", k, aIaddr, 30'(k)); end
      nChecks++; if (aInstr !== tag(30'(k))) begin nErrors++; $display("[TB] FAIL run_instr[%0d] got %h want %h", k, aInstr, tag(30'(k))); end
      nChecks++; if (imemA.IADDR !== 30'(k + 1)) begin nErrors++; $display("[TB] FAIL run_pc[%0d] got %h want %h", k, imemA.IADDR, 30'(k + 1)); end
    end
    nChecks++; if (aCnt !== 32'd4) begin nErrors++; $display("[TB] FAIL run_cnt got %0d want 4", aCnt); end
    nChecks++; if ({aOp, aRa, aRb, aRc} !== {5'd3, 5'd4, 5'd5, 5'd6}) begin nErrors++; $display("[TB] FAIL run_fields got %h want %h", {aOp, aRa, aRb, aRc}, {5'd3, 5'd4, 5'd5, 5'd6}); end
    nChecks++; if (aLink !== 32'h10) begin nErrors++; $display("[TB] FAIL run_link got %h want 10", aLink); end
  endtask

  task automatic test_stall();
    step();
    nChecks++; if (imemA.IADDR !== 30'h5) begin nErrors++; $display("[TB] FAIL stall_pre_pc got %h want 5", imemA.IADDR); end
    STALL = 1'b1;
    #1;
    nChecks++; if (imemA.IREQ !== 1'b0) begin nErrors++; $display("[TB] FAIL stall_ireq got %b want 0", imemA.IREQ); end
    for (int k = 0; k < 3; k++) begin
      step();
      nChecks++; if (imemA.IADDR !== 30'h5) begin nErrors++; $display("[TB] FAIL stall_pc[%0d] got %h want 5", k, imemA.IADDR); end
      nChecks++; if (aIaddr !== 30'h4 || aInstr !== tag(30'h4) || aValid !== 1'b1) begin nErrors++; $display("[TB] FAIL stall_fi[%0d] got %h/%h/%b want 4/%h/1", k, aIaddr, aInstr, aValid, tag(30'h4)); end
      nChecks++; if (aCnt !== 32'd5) begin nErrors++; $display("[TB] FAIL stall_cnt[%0d] got %0d want 5", k, aCnt); end
    end
    STALL = 1'b0;
    step();
    nChecks++; if (aIaddr !== 30'h5) begin nErrors++; $display("[TB] FAIL unstall_fi_iaddr got %h want 5", aIaddr); end
    nChecks++; if (aCnt !== 32'd6) begin nErrors++; $display("[TB] FAIL unstall_cnt got %0d want 6", aCnt); end
    step();
    step();
    nChecks++; if (imemA.IADDR !== 30'h8) begin nErrors++; $display("[TB] FAIL unstall_pc got %h want 8", imemA.IADDR); end
  endtask

  task automatic test_redirect();
    REDIRECT = 1'b1; REDIRECT_ADDR = 30'h100;
    #1;
    nChecks++; if (imemA.IREQ !== 1'b0) begin nErrors++; $display("[TB] FAIL redir_ireq got %b want 0", imemA.IREQ); end
    step();
    REDIRECT = 1'b0;
    nChecks++; if (imemA.IADDR !== 30'h100) begin nErrors++; $display("[TB] FAIL redir_pc got %h want 100", imemA.IADDR); end
    nChecks++; if (aValid !== 1'b0 || aInstr !== 32'h0) begin nErrors++; $display("[TB] FAIL redir_bubble got %b/%h want 0/0", aValid, aInstr); end
    nChecks++; if (aIaddr !== 30'h7) begin nErrors++; $display("[TB] FAIL redir_iaddr_held got %h want 7", aIaddr); end
    nChecks++; if (aCnt !== 32'd8) begin nErrors++; $display("[TB] FAIL redir_cnt got %0d want 8", aCnt); end
    step();
    nChecks++; if (aValid !== 1'b1 || aIaddr !== 30'h100) begin nErrors++; $display("[TB] FAIL redir_target got %b/%h want 1/100", aValid, aIaddr); end
    nChecks++; if (aInstr !== tag(30'h100)) begin nErrors++; $display("[TB] FAIL redir_target_instr got %h want %h", aInstr, tag(30'h100)); end
    nChecks++; if (aCnt !== 32'd9) begin nErrors++; $display("[TB] FAIL redir_target_cnt got %0d want 9", aCnt); end
  endtask

  task automatic test_stall_redirect();
    STALL = 1'b1; REDIRECT = 1'b1; REDIRECT_ADDR = 30'h20;
    step();
    STALL = 1'b0; REDIRECT = 1'b0;
    nChecks++; if (imemA.IADDR !== 30'h20) begin nErrors++; $display("[TB] FAIL both_pc got %h want 20", imemA.IADDR); end
    nChecks++; if (aValid !== 1'b0) begin nErrors++; $display("[TB] FAIL both_valid got %b want 0", aValid); end
    nChecks++; if (aCnt !== 32'd9) begin nErrors++; $display("[TB] FAIL both_cnt got %0d want 9", aCnt); end
  endtask

  task automatic test_back_to_back();
    REDIRECT = 1'b1; REDIRECT_ADDR = 30'h30;
    step();
    REDIRECT_ADDR = 30'h40;
    step();
    REDIRECT = 1'b0; STALL = 1'b1;
    nChecks++; if (imemA.IADDR !== 30'h40) begin nErrors++; $display("[TB] FAIL b2b_pc got %h want 40", imemA.IADDR); end
    nChecks++; if (aValid !== 1'b0) begin nErrors++; $display("[TB] FAIL b2b_valid got %b want 0", aValid); end
    step();
    STALL = 1'b0;
    nChecks++; if (aValid !== 1'b0 || imemA.IADDR !== 30'h40) begin nErrors++; $display("[TB] FAIL b2b_stall got %b/%h want 0/40", aValid, imemA.IADDR); end
  endtask

  task automatic test_async_reset();
    #2;
    RSTN = 1'b0;
    #1;
    nChecks++; if (imemA.IADDR !== 30'h0 || imemA.IREQ !== 1'b0) begin nErrors++; $display("[TB] FAIL areset_bus got %h/%b want 0/0", imemA.IADDR, imemA.IREQ); end
    nChecks++; if (aValid !== 1'b0 || aInstr !== 32'h0 || aIaddr !== 30'h0) begin nErrors++; $display("[TB] FAIL areset_fi got %b/%h/%h want 0/0/0", aValid, aInstr, aIaddr); end
    nChecks++; if (aCnt !== 32'h0 || aLink !== 32'h4) begin nErrors++; $display("[TB] FAIL areset_cnt_link got %0d/%h want 0/4", aCnt, aLink); end
    #1;
    RSTN = 1'b1;
    step();
    nChecks++; if (imemA.IREQ !== 1'b1 || imemA.IADDR !== 30'h0 || aValid !== 1'b0) begin nErrors++; $display("[TB] FAIL areset_boot got %b/%h/%b want 1/0/0", imemA.IREQ, imemA.IADDR, aValid); end
    step();
    nChecks++; if (aValid !== 1'b1 || aIaddr !== 30'h0 || aCnt !== 32'd1) begin nErrors++; $display("[TB] FAIL areset_fetch got %b/%h/%0d want 1/0/1", aValid, aIaddr, aCnt); end
    nChecks++; if (imemA.IADDR !== 30'h1) begin nErrors++; $display("[TB] FAIL areset_pc got %h want 1", imemA.IADDR); end
  endtask

  task automatic test_wrap();
    rstnB = 1'b1;
    step();
    nChecks++; if (imemB.IREQ !== 1'b1 || imemB.IADDR !== 30'h3FFFFFFF) begin nErrors++; $display("[TB] FAIL wrap_start got %b/%h want 1/3fffffff", imemB.IREQ, imemB.IADDR); end
    step();
    nChecks++; if (bValid !== 1'b1 || bIaddr !== 30'h3FFFFFFF) begin nErrors++; $display("[TB] FAIL wrap_fi got %b/%h want 1/3fffffff", bValid, bIaddr); end
    nChecks++; if (bLink !== 32'h0) begin nErrors++; $display("[TB] FAIL wrap_link got %h want 0", bLink); end
    nChecks++; if ({bOp, bRa, bRb, bRc} !== {5'd31, 5'd0, 5'd1, 5'd2}) begin nErrors++; $display("[TB] FAIL wrap_fields got %h want %h", {bOp, bRa, bRb, bRc}, {5'd31, 5'd0, 5'd1, 5'd2}); end
    nChecks++; if (imemB.IADDR !== 30'h0) begin nErrors++; $display("[TB] FAIL wrap_pc got %h want 0", imemB.IADDR); end
    step();
    nChecks++; if (bIaddr !== 30'h0 || bLink !== 32'h4 || bCnt !== 32'd2) begin nErrors++; $display("[TB] FAIL wrap_next got %h/%h/%0d want 0/4/2", bIaddr, bLink, bCnt); end
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
